// File: rtl/traffic_lamp_sr_driver.sv
// traffic_lamp_sr_driver: sequences RED/GREEN/YELLOW through three external SR lamp latches
//
// Ports:
//   clk      - single clock; all state updates on its rising edge
//   reset_n  - asynchronous active-low reset
//   emg      - emergency request (ends a GREEN dwell early, freezes RED while high)
//   lamp_s   - latch set lines   (bit0 red, bit1 yellow, bit2 green)
//   lamp_r   - latch reset lines (same bit order)
//   lamp_en  - latch enable strobes; each latch captures s/r on the rising edge of its enable
//   phase    - current lamp state: 0 RED, 1 GREEN, 2 YELLOW, 3 INIT
//   cmd_busy - high during the SETUP/PULSE/HOLD cycles of a latch command
module traffic_lamp_sr_driver #(
    parameter int PULSE_CYC  = 2,
    parameter int RED_CYC    = 8,
    parameter int GREEN_CYC  = 6,
    parameter int YELLOW_CYC = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       emg,
    output logic [2:0] lamp_s,
    output logic [2:0] lamp_r,
    output logic [2:0] lamp_en,
    output logic [1:0] phase,
    output logic       cmd_busy
);

    localparam int MAX_PR  = (PULSE_CYC > RED_CYC) ? PULSE_CYC : RED_CYC;
    localparam int MAX_GY  = (GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC;
    localparam int MAX_CYC = (MAX_PR > MAX_GY) ? MAX_PR : MAX_GY;
    localparam int CW      = $clog2(MAX_CYC + 1);

    // Counters are loaded with length-1 and the phase ends on the cycle the count reads zero
    localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] RED_LD    = CW'(RED_CYC - 1);
    localparam logic [CW-1:0] GREEN_LD  = CW'(GREEN_CYC - 1);
    localparam logic [CW-1:0] YELLOW_LD = CW'(YELLOW_CYC - 1);

    localparam logic [1:0] PH_RED    = 2'd0;
    localparam logic [1:0] PH_GREEN  = 2'd1;
    localparam logic [1:0] PH_YELLOW = 2'd2;
    localparam logic [1:0] PH_INIT   = 2'd3;

    generate
        if (PULSE_CYC < 1) begin : g_bad_pulse
            $error("PULSE_CYC must be >= 1");
        end
        if (RED_CYC < 1) begin : g_bad_red
            $error("RED_CYC must be >= 1");
        end
        if (GREEN_CYC < 1) begin : g_bad_green
            $error("GREEN_CYC must be >= 1");
        end
        if (YELLOW_CYC < 1) begin : g_bad_yellow
            $error("YELLOW_CYC must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_INIT,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_DWELL
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    cur, cur_nxt;
    logic [2:0]    on_mask, off_mask;
    logic [1:0]    tgt;
    logic [CW-1:0] dwell_ld;

    // The command, its destination and the destination dwell length all follow from the
    // lamp state being left; cur stays constant for the whole command, so s/r cannot move
    // while an enable is high.
    always_comb begin
        on_mask  = (cur == PH_RED)   ? 3'b100 :
                   (cur == PH_GREEN) ? 3'b010 : 3'b001;
        off_mask = (cur == PH_RED)    ? 3'b001 :
                   (cur == PH_GREEN)  ? 3'b100 :
                   (cur == PH_YELLOW) ? 3'b010 : 3'b110;
        tgt      = (cur == PH_RED)   ? PH_GREEN :
                   (cur == PH_GREEN) ? PH_YELLOW : PH_RED;
        dwell_ld = (tgt == PH_RED)   ? RED_LD :
                   (tgt == PH_GREEN) ? GREEN_LD : YELLOW_LD;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
            cnt   <= '0;
            cur   <= PH_INIT;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cur   <= cur_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cur_nxt   = cur;
        case (state)
            ST_INIT: state_nxt = ST_SETUP;
            ST_SETUP: begin
                state_nxt = ST_PULSE;
                cnt_nxt   = PULSE_LD;
            end
            ST_PULSE: begin
                if (cnt == '0) state_nxt = ST_HOLD;
                else cnt_nxt = cnt - 1'b1;
            end
            ST_HOLD: begin
                state_nxt = ST_DWELL;
                cur_nxt   = tgt;
                cnt_nxt   = dwell_ld;
            end
            ST_DWELL: begin
                // GREEN yields to emergency via YELLOW; RED is held by reloading its count
                if (cur == PH_GREEN && emg) state_nxt = ST_SETUP;
                else if (cur == PH_RED && emg) cnt_nxt = RED_LD;
                else if (cnt == '0) state_nxt = ST_SETUP;
                else cnt_nxt = cnt - 1'b1;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        cmd_busy = (state == ST_SETUP) || (state == ST_PULSE) || (state == ST_HOLD);
        lamp_s   = cmd_busy ? on_mask : 3'b000;
        lamp_r   = cmd_busy ? off_mask : 3'b000;
        lamp_en  = (state == ST_PULSE) ? (on_mask | off_mask) : 3'b000;
        phase    = cur;
    end

endmodule

// File: tb/tb_traffic_lamp_sr_driver.sv
// tb_traffic_lamp_sr_driver: directed scoreboard bench for traffic_lamp_sr_driver
module tb_traffic_lamp_sr_driver;

    typedef struct packed {
        logic [2:0] s;
        logic [2:0] r;
        logic [2:0] en;
        logic       busy;
        logic [1:0] ph;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       emg = 1'b0;
    logic [2:0] lamp_s, lamp_r, lamp_en;
    logic [1:0] phase;
    logic       cmd_busy;

    int checks = 0;
    int fails = 0;
    exp_t sb[$];

    traffic_lamp_sr_driver dut (
        .clk(clk),
        .reset_n(reset_n),
        .emg(emg),
        .lamp_s(lamp_s),
        .lamp_r(lamp_r),
        .lamp_en(lamp_en),
        .phase(phase),
        .cmd_busy(cmd_busy)
    );

    always #5 clk = ~clk;

    task automatic push_cmd(input logic [2:0] on, input logic [2:0] off, input logic [1:0] ph);
        sb.push_back('{on, off, 3'b000, 1'b1, ph});
        repeat (2) sb.push_back('{on, off, on | off, 1'b1, ph});
        sb.push_back('{on, off, 3'b000, 1'b1, ph});
    endtask

    task automatic push_dwell(input logic [1:0] ph, input int n);
        repeat (n) sb.push_back('{3'b000, 3'b000, 3'b000, 1'b0, ph});
    endtask

    task automatic step(input logic e, input string tag);
        exp_t x, o;
        emg = e;
        @(posedge clk);
        #1;
        o = '{lamp_s, lamp_r, lamp_en, cmd_busy, phase};
        checks++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty, observed s=%b r=%b en=%b busy=%b ph=%0d", tag, o.s, o.r, o.en, o.busy, o.ph);
        end else begin
            x = sb.pop_front();
            assert (o === x) else begin
                fails++;
                $error("FAIL %s: observed s=%b r=%b en=%b busy=%b ph=%0d expected s=%b r=%b en=%b busy=%b ph=%0d",
                       tag, o.s, o.r, o.en, o.busy, o.ph, x.s, x.r, x.en, x.busy, x.ph);
            end
        end
    endtask

    task automatic run(input int n, input logic e, input string tag);
        repeat (n) step(e, tag);
    endtask

    task automatic chk_rst(input string tag);
        checks++;
        assert ({lamp_s, lamp_r, lamp_en, cmd_busy, phase} === {3'b000, 3'b000, 3'b000, 1'b0, 2'd3}) else begin
            fails++;
            $error("FAIL %s: observed s=%b r=%b en=%b busy=%b ph=%0d expected all zero, ph=3",
                   tag, lamp_s, lamp_r, lamp_en, cmd_busy, phase);
        end
    endtask

    // Per-cycle latch-safety monitor and a model of the three external SR latches
    logic [2:0] ps = 3'b000, pr = 3'b000, pen = 3'b000, latch = 3'b000;
    logic [2:0] want;
    always @(negedge clk) begin
        if (!reset_n) begin
            ps = 3'b000;
            pr = 3'b000;
            pen = 3'b000;
        end else begin
            checks++;
            assert ((lamp_s & lamp_r) === 3'b000) else begin
                fails++;
                $error("FAIL s_and_r: observed %b expected 000", lamp_s & lamp_r);
            end
            checks++;
            assert ((lamp_en & ~pen & ~((lamp_s | lamp_r) & (ps | pr))) === 3'b000) else begin
                fails++;
                $error("FAIL en_setup: observed en=%b s|r=%b prev s|r=%b expected rising en covered", lamp_en, lamp_s | lamp_r, ps | pr);
            end
            checks++;
            assert (lamp_en === 3'b000 || (lamp_s === ps && lamp_r === pr)) else begin
                fails++;
                $error("FAIL sr_stable: observed s=%b r=%b expected s=%b r=%b", lamp_s, lamp_r, ps, pr);
            end
            for (int i = 0; i < 3; i++)
                if (lamp_en[i] && !pen[i]) latch[i] = lamp_s[i] ? 1'b1 : lamp_r[i] ? 1'b0 : latch[i];
            if (!cmd_busy && phase != 2'd3) begin
                want = (phase == 2'd0) ? 3'b001 : (phase == 2'd1) ? 3'b100 : 3'b010;
                checks++;
                assert (latch === want) else begin
                    fails++;
                    $error("FAIL one_lamp: observed latches=%b expected %b in phase %0d", latch, want, phase);
                end
            end
            ps = lamp_s;
            pr = lamp_r;
            pen = lamp_en;
        end
    end

    initial begin
        #1 reset_n = 1'b0;
        #2 chk_rst("por_async");
        @(posedge clk);
        #1 chk_rst("por_held");
        @(negedge clk);
        reset_n = 1'b1;

        // Reset release and one full free-running period
        push_cmd(3'b001, 3'b110, 2'd3);
        push_dwell(2'd0, 8);
        push_cmd(3'b100, 3'b001, 2'd0);
        push_dwell(2'd1, 6);
        push_cmd(3'b010, 3'b100, 2'd1);
        push_dwell(2'd2, 2);
        push_cmd(3'b001, 3'b010, 2'd2);
        push_dwell(2'd0, 8);
        run(40, 1'b0, "free_run");

        // Emergency on the 2nd GREEN cycle; emg also held through the command and YELLOW
        push_cmd(3'b100, 3'b001, 2'd0);
        push_dwell(2'd1, 2);
        push_cmd(3'b010, 3'b100, 2'd1);
        push_dwell(2'd2, 2);
        push_cmd(3'b001, 3'b010, 2'd2);
        push_dwell(2'd0, 8);
        run(6, 1'b0, "emg_green_pre");
        run(11, 1'b1, "emg_green");
        run(7, 1'b0, "emg_green_red");

        // Emergency held 20 cycles from RED entry: RED lasts 8 more cycles after release
        push_cmd(3'b100, 3'b001, 2'd0);
        push_dwell(2'd1, 6);
        push_cmd(3'b010, 3'b100, 2'd1);
        push_dwell(2'd2, 2);
        push_cmd(3'b001, 3'b010, 2'd2);
        push_dwell(2'd0, 28);
        push_cmd(3'b100, 3'b001, 2'd0);
        run(21, 1'b0, "emg_red_pre");
        run(20, 1'b1, "emg_red_hold");
        run(7, 1'b0, "emg_red_tail");

        // Reset mid-PULSE of the RED->GREEN command
        run(2, 1'b0, "rg_setup_pulse");
        sb.delete();
        #2 reset_n = 1'b0;
        #1 chk_rst("mid_pulse_async");
        @(posedge clk);
        #1 chk_rst("mid_pulse_held");
        @(negedge clk);
        reset_n = 1'b1;
        push_cmd(3'b001, 3'b110, 2'd3);
        push_dwell(2'd0, 8);
        run(12, 1'b0, "reinit");

        checks++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL sb_drain: observed %0d left expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/traffic_lamp_sr_driver.md
TRAFFIC_LAMP_SR_DRIVER -- requirements
Module: traffic_lamp_sr_driver

Interface
REQ-001 Parameter PULSE_CYC, default 2: cycles lamp_en is held high per command; legal range >=1.
REQ-002 Parameter RED_CYC, default 8: RED dwell length in cycles; legal range >=1.
REQ-003 Parameter GREEN_CYC, default 6: GREEN dwell length in cycles; legal range >=1.
REQ-004 Parameter YELLOW_CYC, default 2: YELLOW dwell length in cycles; legal range >=1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 emg  input  1  emergency request, synchronous to clk.
REQ-008 lamp_s  output  3  set lines to the three lamp SR latches; bit0 red, bit1 yellow, bit2 green.
REQ-009 lamp_r  output  3  reset lines to the same latches, same bit order.
REQ-010 lamp_en  output  3  per-latch enable strobes; each latch captures s/r on its rising edge.
REQ-011 phase  output  2  lamp state: 0 RED, 1 GREEN, 2 YELLOW, 3 INIT.
REQ-012 cmd_busy  output  1  high while an SR command is in progress.

Function
REQ-013 The block SHALL alternate between dwell states and SR commands; each command is a pair (on_mask, off_mask) with disjoint bits.
REQ-014 Command timing, cycle C0 SETUP: lamp_s=on_mask, lamp_r=off_mask, lamp_en=000.
REQ-015 Command timing, cycles C1..C_PULSE_CYC PULSE: s/r held, lamp_en=on_mask|off_mask.
REQ-016 Command timing, next cycle HOLD: s/r held, lamp_en=000.
REQ-017 Command timing, after HOLD: lamp_s=lamp_r=000.
REQ-018 Each command SHALL last PULSE_CYC+2 cycles, with cmd_busy=1 for exactly those cycles.
REQ-019 lamp_s&lamp_r SHALL be 000 every cycle; the illegal s=r=1 latch input is never driven.
REQ-020 No lamp_en bit SHALL rise unless its s or r bit is already high in the same cycle and the previous one.
REQ-021 lamp_s/lamp_r SHALL be stable throughout any cycle in which lamp_en is nonzero.
REQ-022 Sequence: INIT cmd (on=001, off=110), then RED dwell.
REQ-023 Sequence: RED dwell, then cmd (on=100, off=001), then GREEN dwell.
REQ-024 Sequence: GREEN dwell, then cmd (on=010, off=100), then YELLOW dwell.
REQ-025 Sequence: YELLOW dwell, then cmd (on=001, off=010), then RED dwell, repeating.
REQ-026 phase SHALL update to the new lamp state in the first cycle after HOLD and keep the old value during the command.
REQ-027 Each dwell SHALL last exactly its *_CYC cycles, counted by a down-counter loaded at dwell entry.
REQ-028 The next command's SETUP SHALL occur in the cycle after the last dwell cycle.
REQ-029 emg=1 in any GREEN dwell cycle SHALL end the dwell; the GREEN->YELLOW command starts in the next cycle. GREEN never goes directly to RED.
REQ-030 emg during a command or a YELLOW dwell SHALL have no effect; YELLOW completes normally.
REQ-031 emg=1 during a RED dwell SHALL reload the dwell counter to RED_CYC, so RED holds while emg=1 and lasts RED_CYC cycles after emg falls.
REQ-032 Counter widths SHALL hold max(PULSE_CYC, RED_CYC, GREEN_CYC, YELLOW_CYC) without wrap.

Reset
REQ-033 reset_n=0 SHALL force asynchronously: lamp_s=lamp_r=lamp_en=000, cmd_busy=0, phase=3, all counters 0, FSM=INIT.
REQ-034 Reset during any command or dwell SHALL abort it immediately with no further enable pulse.
REQ-035 The first rising clk edge after reset_n rises SHALL begin the INIT command SETUP cycle.

Verification
REQ-036 Reset release, default parameters:
- cycle0: s=001, r=110, en=000, busy=1.
- cycles1-2: en=111.
- cycle3: en=000, s/r held.
- cycle4: s=r=000, busy=0, phase=0.
REQ-037 Free run, emg=0: RED 8, cmd 4, GREEN 6, cmd 4, YELLOW 2, cmd 4; period 28 cycles; the RED->GREEN cmd drives s=100, r=001.
REQ-038 emg=1 for one cycle in the 2nd GREEN dwell cycle -> the GREEN->YELLOW SETUP (s=010, r=100) follows next cycle; YELLOW lasts 2 cycles, then RED.
REQ-039 emg held high 20 cycles from RED entry -> phase stays 0 and no en pulse occurs; RED->GREEN SETUP occurs 8 cycles after emg falls.
REQ-040 reset_n=0 mid-PULSE of the RED->GREEN command -> all outputs 000 and phase=3 without waiting for clk; after release the INIT sequence of REQ-036 repeats.
REQ-041 Assertions over all scenarios: REQ-019, REQ-020 and REQ-021 hold every cycle, and a latch model fed by lamp_* shows exactly one lamp lit in each dwell.
